// File: rtl/pifo_sched_pkg.sv
//============================================================================
// Module      : pifo_sched_pkg
// Description : Shared constants for the PIFO dequeue scheduler: root info
//               field positions, rank width default and FSM state encoding.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package pifo_sched_pkg;

    localparam int c_pifo_rank_width     = 18;
    localparam int c_root_rank_start_pos = 12;
    // Exclusive upper bound: the rank field is [END_POS-1:START_POS].
    localparam int c_root_rank_end_pos   = 30;
    localparam int c_root_info_valid_pos = 31;
    localparam int c_wait_cnt_width      = 4;

    localparam logic [0:0] c_st_idle     = 1'b0;
    localparam logic [0:0] c_st_wait_pop = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pifo_rank_eligibility.sv
//============================================================================
// Module      : pifo_rank_eligibility
// Description : Extracts one candidate's valid bit and rank, applies the
//               pause threshold and ranks it against the other candidate.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pifo_rank_eligibility
    import pifo_sched_pkg::*;
#(
    parameter int PIFO_RANK_WIDTH = c_pifo_rank_width,
    parameter int PIFO_ROOT_WIDTH = 32,
    parameter int RANK_START_POS  = c_root_rank_start_pos,
    parameter int RANK_END_POS    = c_root_rank_end_pos,
    parameter int VALID_POS       = c_root_info_valid_pos,
    parameter bit TIE_WINS        = 1'b0
) (
    input  logic [PIFO_ROOT_WIDTH-1:0] i_self_info,
    input  logic [PIFO_ROOT_WIDTH-1:0] i_other_info,
    input  logic                       i_pause_valid,
    input  logic [PIFO_RANK_WIDTH-1:0] i_pause_rank,
    output logic                       o_valid,
    output logic                       o_paused,
    output logic                       o_wins
);

    logic [PIFO_RANK_WIDTH-1:0] w_self_rank;
    logic [PIFO_RANK_WIDTH-1:0] w_other_rank;
    logic                       w_unused_info;

    assign w_self_rank  = i_self_info[RANK_END_POS-1:RANK_START_POS];
    assign w_other_rank = i_other_info[RANK_END_POS-1:RANK_START_POS];

    assign o_valid  = i_self_info[VALID_POS];
    assign o_paused = i_pause_valid & (w_self_rank >= i_pause_rank);

    // TIE_WINS lets the calendar instance take equal ranks, keeping FIFO order.
    assign o_wins = TIE_WINS ? (w_self_rank <= w_other_rank)
                             : (w_self_rank <  w_other_rank);

    assign w_unused_info = ^{i_self_info, i_other_info};

endmodule

`default_nettype wire

// File: rtl/pifo_dequeue_scheduler.sv
//============================================================================
// Module      : pifo_dequeue_scheduler
// Description : Chooses between a one-entry hold register (bypass) and the
//               calendar PIFO head, honouring a rank-threshold pause.
//               Optional statistics counters: define PIFO_DEQ_STATS_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pifo_dequeue_scheduler
    import pifo_sched_pkg::*;
#(
    parameter int BUFFER_ADDR_WIDTH        = 12,
    parameter int PIFO_RANK_WIDTH          = c_pifo_rank_width,
    parameter int PIFO_ROOT_WIDTH          = 32,
    parameter int ROOT_RANK_START_POS      = c_root_rank_start_pos,
    parameter int ROOT_RANK_END_POS        = c_root_rank_end_pos,
    parameter int ROOT_PIFO_INFO_VALID_POS = c_root_info_valid_pos,
    parameter int POP_LATENCY              = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_axis_valid,
    output logic                         s_axis_ready,
    input  logic [PIFO_ROOT_WIDTH-1:0]   s_axis_pifo_info,
    input  logic [PIFO_ROOT_WIDTH-1:0]   s_axis_pifo_calendar_top,
    input  logic                         s_axis_gpfc_valid,
    input  logic [PIFO_RANK_WIDTH-1:0]   s_axis_gpfc_pause_rank,
    output logic                         m_cal_pop,
    output logic                         m_cal_enq_valid,
    input  logic                         m_cal_enq_ready,
    output logic [PIFO_ROOT_WIDTH-1:0]   m_cal_enq_info,
    input  logic                         m_axis_tready,
    output logic                         m_axis_valid,
    output logic [BUFFER_ADDR_WIDTH-1:0] m_axis_buf_addr,
    output logic                         m_axis_bypass
`ifdef PIFO_DEQ_STATS_EN
    ,
    output logic [31:0]                  stat_bypass_cnt,
    output logic [31:0]                  stat_pop_cnt,
    output logic [31:0]                  stat_pause_stall_cnt
`endif
);

    logic [0:0]                  r_state_q, w_state_d;
    logic [c_wait_cnt_width-1:0] r_wait_cnt_q, w_wait_cnt_d;
    logic                        r_hold_valid_q, w_hold_valid_d;
    logic [PIFO_ROOT_WIDTH-1:0]  r_hold_info_q, w_hold_info_d;
    logic                        r_out_valid_q, w_out_valid_d;
    logic [BUFFER_ADDR_WIDTH-1:0] r_out_addr_q, w_out_addr_d;
    logic                        r_out_bypass_q, w_out_bypass_d;

    logic w_hold_paused, w_hold_wins, w_hold_info_valid;
    logic w_cal_valid, w_cal_paused, w_cal_wins;
    logic w_idle, w_hold_elig, w_cal_elig;
    logic w_bypass_grant, w_cal_grant;

    pifo_rank_eligibility #(
        .PIFO_RANK_WIDTH (PIFO_RANK_WIDTH),
        .PIFO_ROOT_WIDTH (PIFO_ROOT_WIDTH),
        .RANK_START_POS  (ROOT_RANK_START_POS),
        .RANK_END_POS    (ROOT_RANK_END_POS),
        .VALID_POS       (ROOT_PIFO_INFO_VALID_POS),
        .TIE_WINS        (1'b0)
    ) u_hold_elig (
        .i_self_info   (r_hold_info_q),
        .i_other_info  (s_axis_pifo_calendar_top),
        .i_pause_valid (s_axis_gpfc_valid),
        .i_pause_rank  (s_axis_gpfc_pause_rank),
        .o_valid       (w_hold_info_valid),
        .o_paused      (w_hold_paused),
        .o_wins        (w_hold_wins)
    );

    pifo_rank_eligibility #(
        .PIFO_RANK_WIDTH (PIFO_RANK_WIDTH),
        .PIFO_ROOT_WIDTH (PIFO_ROOT_WIDTH),
        .RANK_START_POS  (ROOT_RANK_START_POS),
        .RANK_END_POS    (ROOT_RANK_END_POS),
        .VALID_POS       (ROOT_PIFO_INFO_VALID_POS),
        .TIE_WINS        (1'b1)
    ) u_cal_elig (
        .i_self_info   (s_axis_pifo_calendar_top),
        .i_other_info  (r_hold_info_q),
        .i_pause_valid (s_axis_gpfc_valid),
        .i_pause_rank  (s_axis_gpfc_pause_rank),
        .o_valid       (w_cal_valid),
        .o_paused      (w_cal_paused),
        .o_wins        (w_cal_wins)
    );

    assign w_idle      = (r_state_q == c_st_idle);
    assign w_hold_elig = r_hold_valid_q & w_hold_info_valid & ~w_hold_paused;
    assign w_cal_elig  = w_cal_valid & ~w_cal_paused;

    assign w_bypass_grant = w_idle & m_axis_tready & w_hold_elig &
                            (~w_cal_valid | w_cal_paused | w_hold_wins);
    assign w_cal_grant    = w_idle & m_axis_tready & ~w_bypass_grant & w_cal_elig &
                            (~r_hold_valid_q | w_cal_wins | w_hold_paused);

    // Gated with rstn so both strobes drop the instant reset is asserted.
    assign m_cal_pop       = w_cal_grant & rstn;
    assign m_cal_enq_valid = r_hold_valid_q & ~w_bypass_grant & ~w_cal_grant & rstn;
    assign m_cal_enq_info  = r_hold_info_q;
    assign s_axis_ready    = ~r_hold_valid_q;

    assign m_axis_valid    = r_out_valid_q;
    assign m_axis_buf_addr = r_out_addr_q;
    assign m_axis_bypass   = r_out_bypass_q;

    always_comb begin
        w_state_d      = r_state_q;
        w_wait_cnt_d   = r_wait_cnt_q;
        w_hold_valid_d = r_hold_valid_q;
        w_hold_info_d  = r_hold_info_q;
        w_out_valid_d  = 1'b0;
        w_out_addr_d   = r_out_addr_q;
        w_out_bypass_d = r_out_bypass_q;

        case (r_state_q)
            c_st_idle: begin
                if (w_cal_grant) begin
                    w_state_d    = c_st_wait_pop;
                    w_wait_cnt_d = c_wait_cnt_width'(POP_LATENCY - 1);
                end
            end
            c_st_wait_pop: begin
                if (r_wait_cnt_q == '0) begin
                    w_state_d = c_st_idle;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q - 1'b1;
                end
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase

        if (w_bypass_grant) begin
            w_out_valid_d  = 1'b1;
            w_out_addr_d   = r_hold_info_q[BUFFER_ADDR_WIDTH-1:0];
            w_out_bypass_d = 1'b1;
        end else if (w_cal_grant) begin
            w_out_valid_d  = 1'b1;
            w_out_addr_d   = s_axis_pifo_calendar_top[BUFFER_ADDR_WIDTH-1:0];
            w_out_bypass_d = 1'b0;
        end

        // Latching only from an empty register makes latch+bypass mutually exclusive.
        if (r_hold_valid_q) begin
            if (w_bypass_grant || (m_cal_enq_valid && m_cal_enq_ready)) begin
                w_hold_valid_d = 1'b0;
            end
        end else if (s_axis_valid && s_axis_pifo_info[ROOT_PIFO_INFO_VALID_POS]) begin
            w_hold_valid_d = 1'b1;
            w_hold_info_d  = s_axis_pifo_info;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q      <= c_st_idle;
            r_wait_cnt_q   <= '0;
            r_hold_valid_q <= 1'b0;
            r_hold_info_q  <= '0;
            r_out_valid_q  <= 1'b0;
            r_out_addr_q   <= '0;
            r_out_bypass_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_wait_cnt_q   <= w_wait_cnt_d;
            r_hold_valid_q <= w_hold_valid_d;
            r_hold_info_q  <= w_hold_info_d;
            r_out_valid_q  <= w_out_valid_d;
            r_out_addr_q   <= w_out_addr_d;
            r_out_bypass_q <= w_out_bypass_d;
        end
    end

`ifdef PIFO_DEQ_STATS_EN
    logic [31:0] r_stat_bypass_q, w_stat_bypass_d;
    logic [31:0] r_stat_pop_q, w_stat_pop_d;
    logic [31:0] r_stat_stall_q, w_stat_stall_d;
    logic        w_pause_stall;

    assign w_pause_stall = w_idle & ~w_bypass_grant & ~w_cal_grant &
                           ((r_hold_valid_q & w_hold_paused) | (w_cal_valid & w_cal_paused));

    always_comb begin
        w_stat_bypass_d = r_stat_bypass_q;
        w_stat_pop_d    = r_stat_pop_q;
        w_stat_stall_d  = r_stat_stall_q;
        if (w_bypass_grant && (r_stat_bypass_q != '1)) w_stat_bypass_d = r_stat_bypass_q + 32'd1;
        if (w_cal_grant && (r_stat_pop_q != '1))       w_stat_pop_d    = r_stat_pop_q + 32'd1;
        if (w_pause_stall && (r_stat_stall_q != '1))   w_stat_stall_d  = r_stat_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_bypass_q <= '0;
            r_stat_pop_q    <= '0;
            r_stat_stall_q  <= '0;
        end else begin
            r_stat_bypass_q <= w_stat_bypass_d;
            r_stat_pop_q    <= w_stat_pop_d;
            r_stat_stall_q  <= w_stat_stall_d;
        end
    end

    assign stat_bypass_cnt      = r_stat_bypass_q;
    assign stat_pop_cnt         = r_stat_pop_q;
    assign stat_pause_stall_cnt = r_stat_stall_q;
`endif

endmodule

`default_nettype wire
